// File: rtl/motoro3_commutator_ramp_if.sv
// motoro3_commutator_ramp_if
//   Bundles the run controls, the phase drive and the status of the six-step
//   commutation sequencer.
//   master : run controller side (drives start/dir/brake/period_tgt)
//   slave  : sequencer side (drives phase selects and status)
//   Signals: start, dir, brake, period_tgt[CNT_W]       -> sequencer
//            aE/bE/cE, aH1_L0/bH1_L0/cH1_L0, step[4],
//            cnt[CNT_W], busy, at_speed, round_cnt[ROUND_W] <- sequencer
interface motoro3_commutator_ramp_if #(
  parameter int CNT_W   = 25,
  parameter int ROUND_W = 32
);
  logic               start;
  logic               dir;
  logic               brake;
  logic [CNT_W-1:0]   period_tgt;
  logic               aE;
  logic               bE;
  logic               cE;
  logic               aH1_L0;
  logic               bH1_L0;
  logic               cH1_L0;
  logic [3:0]         step;
  logic [CNT_W-1:0]   cnt;
  logic               busy;
  logic               at_speed;
  logic [ROUND_W-1:0] round_cnt;

  modport master (
    output start, dir, brake, period_tgt,
    input  aE, bE, cE, aH1_L0, bH1_L0, cH1_L0, step, cnt, busy, at_speed, round_cnt
  );

  modport slave (
    input  start, dir, brake, period_tgt,
    output aE, bE, cE, aH1_L0, bH1_L0, cH1_L0, step, cnt, busy, at_speed, round_cnt
  );
endinterface

// File: rtl/motoro3_commutator_ramp.sv
// motoro3_commutator_ramp
//   Six-step BLDC commutation sequencer with direction control, a soft-start
//   step-period ramp toward a runtime target, and a brake state (all low
//   sides on).
//   Ports:
//     clk   : system clock, all logic on posedge
//     nRst  : asynchronous active-low reset
//     bus   : motoro3_commutator_ramp_if.slave
//             in : start (level, rising edge starts), dir (0 fwd, 1 rev),
//                  brake (level, highest priority), period_tgt (0 means 1)
//             out: per-phase enables / high-low selects, step (0 idle,
//                  1..6 run, 7 brake), cnt (dwell down-counter), busy,
//                  at_speed, round_cnt
//   Build option: define MOTORO3_ROUND_CNT_EN to include the saturating
//   electrical-revolution counter; otherwise round_cnt is tied to 0.
module motoro3_commutator_ramp #(
  parameter int CNT_W      = 25,
  parameter int RAMP_START = 16667,
  parameter int RAMP_DEC   = 16,
  parameter int ROUND_W    = 32
) (
  input  logic                       clk,
  input  logic                       nRst,
  motoro3_commutator_ramp_if.slave   bus
);

  localparam logic [CNT_W-1:0] START_P = CNT_W'(RAMP_START);
  localparam logic [CNT_W-1:0] DEC_P   = CNT_W'(RAMP_DEC);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_BRAKE} state_t;

  state_t           state, state_n;
  logic [3:0]       step_n;
  logic [CNT_W-1:0] cnt_n;
  logic [CNT_W-1:0] period, period_n;
  logic [CNT_W-1:0] tgt_clamp;
  logic             start_d;
  logic             start_up;

  function automatic logic [CNT_W-1:0] clamp_tgt(input logic [CNT_W-1:0] t);
    return (t == '0) ? CNT_W'(1) : t;
  endfunction

  // Moves cur toward t by at most DEC_P. Each branch only steps while the
  // distance exceeds DEC_P, so the result stays between cur and t and can
  // neither wrap nor drop below the (>=1) target.
  function automatic logic [CNT_W-1:0] ramp_period(input logic [CNT_W-1:0] cur,
                                                   input logic [CNT_W-1:0] t);
    if (cur < t)
      return ((t - cur) > DEC_P) ? cur + DEC_P : t;
    else if (cur > t)
      return ((cur - t) > DEC_P) ? cur - DEC_P : t;
    return cur;
  endfunction

  function automatic logic [3:0] next_step(input logic [3:0] s, input logic rev);
    if (rev)
      return (s == 4'd1) ? 4'd6 : s - 4'd1;
    return (s == 4'd6) ? 4'd1 : s + 4'd1;
  endfunction

  // {aE,bE,cE,aH,bH,cH}
  function automatic logic [5:0] phase_decode(input logic [3:0] s);
    case (s)
      4'd1:    return 6'b101_100;
      4'd2:    return 6'b011_010;
      4'd3:    return 6'b110_010;
      4'd4:    return 6'b101_001;
      4'd5:    return 6'b011_001;
      4'd6:    return 6'b110_100;
      4'd7:    return 6'b111_000;
      default: return 6'b000_000;
    endcase
  endfunction

  assign start_up  = bus.start & ~start_d;
  assign tgt_clamp = clamp_tgt(bus.period_tgt);

`ifdef MOTORO3_ROUND_CNT_EN
  logic wrap;
`endif

  // Next-state selection in priority order: brake, brake release, stop,
  // new start, dwell expiry.
  always_comb begin
    state_n  = state;
    step_n   = bus.step;
    cnt_n    = bus.cnt;
    period_n = period;
`ifdef MOTORO3_ROUND_CNT_EN
    wrap     = 1'b0;
`endif
    if (bus.brake) begin
      state_n = ST_BRAKE;
      step_n  = 4'd7;
      cnt_n   = '0;
    end else if (state == ST_BRAKE) begin
      // Release always lands in idle; a fresh start edge is needed to run.
      state_n = ST_IDLE;
      step_n  = 4'd0;
      cnt_n   = '0;
    end else if (!bus.start) begin
      state_n  = ST_IDLE;
      step_n   = 4'd0;
      cnt_n    = '0;
      period_n = START_P;
    end else if (start_up) begin
      state_n  = ST_RUN;
      step_n   = 4'd1;
      cnt_n    = START_P;
      period_n = START_P;
    end else if (state == ST_RUN) begin
      if (bus.cnt == '0) begin
        step_n   = next_step(bus.step, bus.dir);
        period_n = ramp_period(period, tgt_clamp);
        cnt_n    = period_n;
`ifdef MOTORO3_ROUND_CNT_EN
        wrap     = bus.dir ? (bus.step == 4'd1) : (bus.step == 4'd6);
`endif
      end else begin
        cnt_n = bus.cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state      <= ST_IDLE;
      start_d    <= 1'b0;
      period     <= START_P;
      bus.step   <= 4'd0;
      bus.cnt    <= '0;
      bus.busy   <= 1'b0;
      bus.at_speed <= 1'b0;
      {bus.aE, bus.bE, bus.cE, bus.aH1_L0, bus.bH1_L0, bus.cH1_L0} <= 6'b0;
    end else begin
      state      <= state_n;
      start_d    <= bus.start;
      period     <= period_n;
      bus.step   <= step_n;
      bus.cnt    <= cnt_n;
      bus.busy   <= (state_n == ST_RUN);
      bus.at_speed <= (state_n == ST_RUN) && (period_n == tgt_clamp);
      {bus.aE, bus.bE, bus.cE, bus.aH1_L0, bus.bH1_L0, bus.cH1_L0} <= phase_decode(step_n);
    end
  end

`ifdef MOTORO3_ROUND_CNT_EN
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst)
      bus.round_cnt <= '0;
    else if (step_n == 4'd0 || step_n == 4'd7)
      bus.round_cnt <= '0;
    else if (wrap && (bus.round_cnt != {ROUND_W{1'b1}}))
      bus.round_cnt <= bus.round_cnt + 1'b1;
  end
`else
  assign bus.round_cnt = {ROUND_W{1'b0}};
`endif

endmodule
